// File: rtl/dec_4_16_3_8_pipe_pkg.sv
// Shared constants, FSM encoding and stage-1 payload for the 4:16 decoder pipe.
package dec_4_16_3_8_pipe_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned LINES  = 16;
  localparam int unsigned BANK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Stage-1 beat: code to decode plus its enable.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              en;
  } beat_t;

endpackage

// File: rtl/dec_4_16_3_8_pipe_dec_3_8.sv
// 3:8 one-hot decoder bank with enable.
//   i   : 3-bit code
//   enb : bank enable; 0 forces an all-zero output
//   y   : one-hot result
module dec_3_8 (
  input  logic [2:0] i,
  input  logic       enb,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (enb) y = 8'(8'h01 << i);
  end

endmodule

// File: rtl/dec_4_16_3_8_pipe.sv
// Pipelined 4:16 one-hot decoder (two 3:8 banks) with valid/ready streams and
// a scan sequencer that walks codes 0..SCAN_LAST through the same pipeline.
//   clk, rst_n               : clock, async active-low reset
//   in_valid/in_ready        : input handshake, in_code + in_en payload
//   scan_start / scan_busy   : scan request pulse / scan in progress
//   out_valid/out_ready      : output handshake, out_y + out_code payload
module dec_4_16_3_8_pipe
  import dec_4_16_3_8_pipe_pkg::*;
#(
  parameter int unsigned SCAN_LAST = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_en,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINES-1:0]  out_y,
  output logic [CODE_W-1:0] out_code
);

  localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(SCAN_LAST);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] cnt_q, cnt_d;
  beat_t             s1_q, s1_d;
  logic              s1_valid_q, s1_valid_d;
  logic              out_valid_q, out_valid_d;
  logic [LINES-1:0]  out_y_q, out_y_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;

  logic              s1_adv, s2_adv;
  logic [BANK_W-1:0] y_lo, y_hi;

  assign s2_adv    = ~out_valid_q | out_ready;
  assign s1_adv    = ~s1_valid_q | s2_adv;
  assign in_ready  = s1_adv & (state_q == ST_IDLE);
  assign scan_busy = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_code  = out_code_q;

  // code[3] selects which bank is enabled; the other bank stays all-zero.
  dec_3_8 u_bank_lo (
    .i   (s1_q.code[2:0]),
    .enb (s1_q.en & ~s1_q.code[3]),
    .y   (y_lo)
  );

  dec_3_8 u_bank_hi (
    .i   (s1_q.code[2:0]),
    .enb (s1_q.en & s1_q.code[3]),
    .y   (y_hi)
  );

  // Scan FSM, stage-1 source select and stage-2 capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_code_d  = out_code_q;

    unique case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      end
      ST_SCAN: begin
        if (s1_adv) begin
          cnt_d = cnt_q + CODE_W'(1);
          if (cnt_q == LAST_CODE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !out_valid_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Stage 1 takes external beats in IDLE, sequencer beats in SCAN, nothing in DRAIN.
    if (s1_adv) begin
      s1_valid_d = 1'b0;
      if (state_q == ST_IDLE) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_d.code = in_code;
          s1_d.en   = in_en;
        end
      end else if (state_q == ST_SCAN) begin
        s1_valid_d = 1'b1;
        s1_d.code  = cnt_q;
        s1_d.en    = 1'b1;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_y_d    = {y_hi, y_lo};
        out_code_d = s1_q.code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_code_q  <= out_code_d;
    end
  end

endmodule

// File: tb/tb_dec_4_16_3_8_pipe.sv
// Directed bench for dec_4_16_3_8_pipe with an in-order result scoreboard.
module tb_dec_4_16_3_8_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_code;
  logic        in_en;
  logic        scan_start;
  logic        scan_busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic [3:0]  out_code;

  int n_cmp = 0;
  int n_err = 0;

  logic [19:0] exp_q[$];   // {code, y}
  bit          accepted;
  bit          fired;
  int          sent;
  int          nfire;
  logic [15:0] ev;

  dec_4_16_3_8_pipe #(.SCAN_LAST(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_en      (in_en),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_code   (out_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called with inputs settled before the edge: log handshakes, then advance one clock.
  task automatic step();
    logic [19:0] e;
    accepted = in_valid && in_ready;
    fired    = out_valid && out_ready;
    if (accepted) begin
      e[19:16] = in_code;
      e[15:0]  = in_en ? 16'(16'h0001 << in_code) : 16'h0000;
      exp_q.push_back(e);
    end
    if (scan_start && !scan_busy) begin
      for (int k = 0; k < 16; k++) begin
        e[19:16] = 4'(k);
        e[15:0]  = 16'(16'h0001 << k);
        exp_q.push_back(e);
      end
    end
    if (fired) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_y", 32'(out_y), 32'(e[15:0]));
        check("sb_code", 32'(out_code), 32'(e[19:16]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Runs an already-started scan to completion and checks its timing.
  task automatic run_scan(input string tag, input int exp_n, input logic [15:0] first_y);
    bit done = 1'b0;
    int lastc = -10;
    nfire = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      scan_start = (c == 5);
      #2;
      if (scan_busy) begin
        check({tag, "_rdy"}, 32'(in_ready), 32'd0);
      end else begin
        done = 1'b1;
        check({tag, "_fall"}, 32'(c), 32'(lastc + 2));
      end
      if (out_valid && nfire == 0) check({tag, "_first"}, 32'(out_y), 32'(first_y));
      step();
      if (fired) begin
        nfire++;
        lastc = c;
      end
    end
    scan_start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cnt"}, 32'(nfire), 32'(exp_n));
    check({tag, "_sb"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_code    = 4'd0;
    in_en      = 1'b0;
    scan_start = 1'b0;
    out_ready  = 1'b1;
    #12;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_y", 32'(out_y), 32'h0000);
    check("rst_code", 32'(out_code), 32'd0);
    check("rst_busy", 32'(scan_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    #2;
    check("rst_rdy", 32'(in_ready), 32'd1);
    step();

    // Streaming 0..15 back-to-back, two-cycle latency.
    for (int i = 0; i < 18; i++) begin
      in_valid  = (i < 16);
      in_code   = 4'(i);
      in_en     = 1'b1;
      out_ready = 1'b1;
      #2;
      if (i < 16) check("stream_rdy", 32'(in_ready), 32'd1);
      if (i >= 2) begin
        ev = 16'h0001 << (i - 2);
        check("stream_vld", 32'(out_valid), 32'd1);
        check("stream_lat", 32'(out_y), 32'(ev));
      end
      if (i == 5)  check("stream_3", 32'(out_y), 32'h0008);
      if (i == 13) check("stream_11", 32'(out_y), 32'h0800);
      step();
    end
    in_valid = 1'b0;
    #2;
    step();

    // Disabled beat: all-zero word, code echoed.
    in_valid = 1'b1;
    in_code  = 4'd9;
    in_en    = 1'b0;
    #2;
    step();
    in_valid = 1'b0;
    #2;
    step();
    #2;
    check("dis_vld", 32'(out_valid), 32'd1);
    check("dis_y", 32'(out_y), 32'h0000);
    check("dis_code", 32'(out_code), 32'd9);
    step();
    in_en = 1'b1;

    // Backpressure: 5,6,7 with out_ready low for five cycles.
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b0;
      in_valid  = (sent < 3);
      in_code   = 4'(5 + sent);
      #2;
      if (c >= 2) begin
        check("bp_hold", 32'(out_y), 32'h0020);
        check("bp_rdy", 32'(in_ready), 32'd0);
      end
      step();
      if (accepted) sent++;
    end
    nfire = 0;
    for (int c = 0; c < 10; c++) begin
      out_ready = 1'b1;
      in_valid  = (sent < 3);
      in_code   = 4'(5 + sent);
      #2;
      if (c == 0) check("bp_rel_first", 32'(out_y), 32'h0020);
      step();
      if (accepted) sent++;
      if (fired) nfire++;
    end
    in_valid = 1'b0;
    check("bp_sent", 32'(sent), 32'd3);
    check("bp_cnt", 32'(nfire), 32'd3);
    check("bp_lost", 32'(exp_q.size()), 32'd0);

    // Scan 0..15 with an ignored restart mid-scan.
    scan_start = 1'b1;
    #2;
    step();
    run_scan("scan", 16, 16'h0001);

    // scan_start together with an external beat of code 4.
    in_valid   = 1'b1;
    in_code    = 4'd4;
    in_en      = 1'b1;
    scan_start = 1'b1;
    #2;
    check("simul_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    run_scan("simul", 17, 16'h0010);

    // Reset mid-scan while stalled.
    scan_start = 1'b1;
    #2;
    step();
    scan_start = 1'b0;
    out_ready  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      step();
    end
    #2;
    check("arst_pre_vld", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_vld", 32'(out_valid), 32'd0);
    check("arst_y", 32'(out_y), 32'h0000);
    check("arst_code", 32'(out_code), 32'd0);
    check("arst_busy", 32'(scan_busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 4'd13;
    in_en     = 1'b1;
    #2;
    check("post_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    #2;
    step();
    #2;
    check("post_vld", 32'(out_valid), 32'd1);
    check("post_y", 32'(out_y), 32'h2000);
    check("post_code", 32'(out_code), 32'd13);
    step();
    check("post_sb", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
